sdram_wb_responder: RTL and testbench
=====================================

// Module: sdram_wb_responder
// PURPOSE
//  Board-side responder for the kernel's sdram_* bus (stb/we/sel/adr/out -> ack/dat).
//  Latches each kernel transaction, issues one request to the req/ack SDRAM controller core,
//  then returns sdram_ack and read data. Sits between the TOPBOARD kernel and the controller.
//  Clock domain: clk_p only.
// PARAMETERS
//  AW       21   word-address width (sdram_adr[AW:1])
//  DW       16   data width
//  TIMEOUT  1023 max cycles to wait for controller ack before forced completion
// PORTS
//  clk_p         in   1   processor clock, direct phase
//  sdram_reset   in   1   synchronous active-high reset
//  sdram_stb     in   1   kernel transaction strobe
//  sdram_we      in   1   1=write, 0=read
//  sdram_sel     in   2   byte selects: [1]=high, [0]=low
//  sdram_adr     in   AW  word address
//  sdram_out     in   DW  write data from kernel
//  sdram_dat     out  DW  read data to kernel
//  sdram_ack     out  1   transaction acknowledge
//  sdram_ready   out  1   registered copy of ctl_init_done
//  ctl_wr_req    out  1   controller write request
//  ctl_rd_req    out  1   controller read request
//  ctl_wr_ack    in   1   controller write done, 1-cycle pulse
//  ctl_rd_ack    in   1   controller read data valid, 1-cycle pulse
//  ctl_addr      out  AW+1  {1'b0, latched adr}
//  ctl_wdata     out  DW  latched write data
//  ctl_rdata     in   DW  controller read data
//  ctl_udqm      out  1   high-byte mask; 1 = masked
//  ctl_ldqm      out  1   low-byte mask; 1 = masked
//  ctl_init_done in   1   controller init complete
//  tmo_err       out  1   sticky: a timeout occurred; cleared by reset only
// BEHAVIOUR
//  Reset state (synchronous, active-high):
//   - all outputs 0; masks 0; FSM in IDLE.
//   - Reset mid-transaction drops ctl_*_req on the next edge; no ack is issued.
//  FSM states: IDLE, WREQ, RREQ, DONE, DRAIN.
//  IDLE:
//   - Waits for sdram_stb & sdram_ready & ~sdram_ack.
//   - On that edge, latch adr, out, sel and we.
//   - Masks: read -> udqm=ldqm=0; write -> udqm=~sel[1], ldqm=~sel[0].
//   - Write with sel=00 -> DONE directly; no controller access.
//   - Otherwise go to WREQ (write) or RREQ (read).
//   - stb while sdram_ready=0: stay in IDLE; the kernel waits.
//  WREQ/RREQ:
//   - Request held high until the matching ctl ack pulse.
//   - RREQ captures ctl_rdata into sdram_dat on the ctl_rd_ack cycle.
//   - Either state -> DONE; the request deasserts the same edge.
//   - Wrong-type ack is ignored.
//  DONE:
//   - sdram_ack = 1 while sdram_stb = 1.
//   - stb low -> IDLE, ack 0 on the following edge.
//  DRAIN:
//   - Entered if stb drops while in WREQ/RREQ (kernel abort).
//   - Request stays until the controller ack, then -> IDLE.
//   - No sdram_ack; read data discarded.
//  Timeout:
//   - 10-bit counter clears on WREQ/RREQ entry and counts while waiting.
//   - At TIMEOUT: drop the request, set tmo_err, sdram_dat = 0, go to DONE (ack the kernel).
//  Latency:
//   - Request asserted 1 cycle after the stb edge.
//   - sdram_ack rises 1 cycle after the ctl ack pulse.
//   - Data is stable from the ack until the next transaction is latched.
//  Back-to-back: a new transaction is accepted only after stb has been seen low (IDLE).
// CONFIGURATION
//  `SDRAM_RDCACHE_EN defined: one-word read-hit register (tag AW bits + valid bit).
//   - Read whose adr matches the valid tag -> DONE next cycle, no controller access.
//   - Completed read loads the tag and data.
//   - Write to the tagged adr merges the selected bytes into the cached word.
//   - Reset or timeout clears valid.
//  Undefined: every read goes to the controller.
// STRUCTURE
//  Shared package/include (sdram_pkg.vh):
//   - FSM state localparams
//   - DW/AW defaults
//   - TIMEOUT width constant
//  Single module. The optional cache is one `ifdef block; no sub-module.
// TESTING
//  1. Write adr=0x01234, out=0x5A5A, sel=11.
//     -> ctl_wr_req 1 cycle after stb; udqm=ldqm=0; ack 1 cycle after ctl_wr_ack.
//  2. Read adr=0x01234; controller returns 0xBEEF after 6 cycles.
//     -> sdram_dat=0xBEEF, ack held until stb low, then 0.
//  3. Byte write sel=10 -> udqm=0, ldqm=1. Write with sel=00 -> ack with no ctl_wr_req.
//  4. Drop stb 2 cycles into a read.
//     -> no sdram_ack; rd_req held until ctl_rd_ack; next stb accepted afterwards.
//  5. Controller never acks.
//     -> ack at TIMEOUT+1 cycles, dat=0, tmo_err=1.
//     Reset mid-WREQ -> wr_req 0 next cycle.
//  6. With SDRAM_RDCACHE_EN: read 0x00100 twice.
//     -> second read acks 2 cycles after stb with no ctl_rd_req.
//     Write high byte 0x12 to 0x00100, then read -> 0x12xx returned from cache.

Source files
------------

// File: rtl/sdram_wb_responder_pkg.sv
// rtl/sdram_wb_responder_pkg.sv - shared FSM states, default widths and timeout constants for the sdram_* responder
package sdram_wb_responder_pkg;

  // Responder FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WREQ  = 3'd1,
    ST_RREQ  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam int SDRAM_AW      = 21;
  localparam int SDRAM_DW      = 16;
  localparam int SDRAM_TIMEOUT = 1023;

  // Width of the controller-ack wait counter
  localparam int TMO_W = 10;

endpackage

// File: rtl/sdram_wb_responder.sv
// rtl/sdram_wb_responder.sv - kernel sdram_* bus responder driving a req/ack SDRAM controller; `SDRAM_RDCACHE_EN adds a one-word read cache
module sdram_wb_responder
  import sdram_wb_responder_pkg::*;
#(
  parameter int AW      = SDRAM_AW,
  parameter int DW      = SDRAM_DW,
  parameter int TIMEOUT = SDRAM_TIMEOUT
) (
  input  logic          clk_p,
  input  logic          sdram_reset,
  input  logic          sdram_stb,
  input  logic          sdram_we,
  input  logic [1:0]    sdram_sel,
  input  logic [AW-1:0] sdram_adr,
  input  logic [DW-1:0] sdram_out,
  output logic [DW-1:0] sdram_dat,
  output logic          sdram_ack,
  output logic          sdram_ready,
  output logic          ctl_wr_req,
  output logic          ctl_rd_req,
  input  logic          ctl_wr_ack,
  input  logic          ctl_rd_ack,
  output logic [AW:0]   ctl_addr,
  output logic [DW-1:0] ctl_wdata,
  input  logic [DW-1:0] ctl_rdata,
  output logic          ctl_udqm,
  output logic          ctl_ldqm,
  input  logic          ctl_init_done,
  output logic          tmo_err
);

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);
  localparam int HB = DW / 2;

  state_t           state_q;
  logic [AW-1:0]    adr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    dat_q;
  logic             we_q;
  logic             ack_q;
  logic             ready_q;
  logic             wr_req_q;
  logic             rd_req_q;
  logic             udqm_q;
  logic             ldqm_q;
  logic             tmo_q;
  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;
  logic             ack_match_d;

`ifdef SDRAM_RDCACHE_EN
  logic [AW-1:0]    tag_q;
  logic [DW-1:0]    cdata_q;
  logic             valid_q;
  logic             hit_d;

  // Read hit when the incoming address matches the cached tag
  always_comb begin
    hit_d = valid_q && (sdram_adr == tag_q);
  end
`endif

  // Wait-counter increment and the ack matching the outstanding request type
  always_comb begin
    cnt_d       = cnt_q + TMO_W'(1);
    ack_match_d = we_q ? ctl_wr_ack : ctl_rd_ack;
  end

  // Transaction FSM with registered bus and controller outputs
  always_ff @(posedge clk_p) begin
    if (sdram_reset) begin
      state_q  <= ST_IDLE;
      adr_q    <= '0;
      wdata_q  <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      ack_q    <= 1'b0;
      ready_q  <= 1'b0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      udqm_q   <= 1'b0;
      ldqm_q   <= 1'b0;
      tmo_q    <= 1'b0;
      cnt_q    <= '0;
`ifdef SDRAM_RDCACHE_EN
      tag_q    <= '0;
      cdata_q  <= '0;
      valid_q  <= 1'b0;
`endif
    end else begin
      ready_q <= ctl_init_done;
      case (state_q)
        ST_IDLE: begin
          if (sdram_stb && ready_q && !ack_q) begin
            adr_q   <= sdram_adr;
            wdata_q <= sdram_out;
            we_q    <= sdram_we;
            cnt_q   <= '0;
            if (sdram_we) begin
              udqm_q <= ~sdram_sel[1];
              ldqm_q <= ~sdram_sel[0];
`ifdef SDRAM_RDCACHE_EN
              if (hit_d) begin
                if (sdram_sel[1]) cdata_q[DW-1:HB] <= sdram_out[DW-1:HB];
                if (sdram_sel[0]) cdata_q[HB-1:0]  <= sdram_out[HB-1:0];
              end
`endif
              if (sdram_sel == 2'b00) begin
                state_q <= ST_DONE;
              end else begin
                state_q  <= ST_WREQ;
                wr_req_q <= 1'b1;
              end
            end else begin
              udqm_q <= 1'b0;
              ldqm_q <= 1'b0;
`ifdef SDRAM_RDCACHE_EN
              if (hit_d) begin
                dat_q   <= cdata_q;
                state_q <= ST_DONE;
              end else begin
                state_q  <= ST_RREQ;
                rd_req_q <= 1'b1;
              end
`else
              state_q  <= ST_RREQ;
              rd_req_q <= 1'b1;
`endif
            end
          end
        end
        ST_WREQ, ST_RREQ: begin
          if (ack_match_d) begin
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            if (sdram_stb) begin
              if (!we_q) begin
                dat_q <= ctl_rdata;
`ifdef SDRAM_RDCACHE_EN
                tag_q   <= adr_q;
                cdata_q <= ctl_rdata;
                valid_q <= 1'b1;
`endif
              end
              ack_q   <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (!sdram_stb) begin
            state_q <= ST_DRAIN;
          end else if (cnt_q == TMO_LIM) begin
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            tmo_q    <= 1'b1;
            dat_q    <= '0;
            ack_q    <= 1'b1;
            state_q  <= ST_DONE;
`ifdef SDRAM_RDCACHE_EN
            valid_q  <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_DRAIN: begin
          // Kernel has gone; finish the controller handshake silently
          if (ack_match_d) begin
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            state_q  <= ST_IDLE;
          end else if (cnt_q == TMO_LIM) begin
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            tmo_q    <= 1'b1;
            state_q  <= ST_IDLE;
`ifdef SDRAM_RDCACHE_EN
            valid_q  <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_DONE: begin
          ack_q <= sdram_stb;
          if (!sdram_stb) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sdram_dat   = dat_q;
  assign sdram_ack   = ack_q;
  assign sdram_ready = ready_q;
  assign ctl_wr_req  = wr_req_q;
  assign ctl_rd_req  = rd_req_q;
  assign ctl_addr    = {1'b0, adr_q};
  assign ctl_wdata   = wdata_q;
  assign ctl_udqm    = udqm_q;
  assign ctl_ldqm    = ldqm_q;
  assign tmo_err     = tmo_q;

endmodule

// File: tb/tb_sdram_wb_responder.sv
// tb/tb_sdram_wb_responder.sv - directed table-driven bench for sdram_wb_responder
module tb_sdram_wb_responder;

  localparam int TMO = 1023;

  logic        clk_p = 1'b0;
  logic        sdram_reset;
  logic        sdram_stb;
  logic        sdram_we;
  logic [1:0]  sdram_sel;
  logic [20:0] sdram_adr;
  logic [15:0] sdram_out;
  logic [15:0] sdram_dat;
  logic        sdram_ack;
  logic        sdram_ready;
  logic        ctl_wr_req;
  logic        ctl_rd_req;
  logic        ctl_wr_ack;
  logic        ctl_rd_ack;
  logic [21:0] ctl_addr;
  logic [15:0] ctl_wdata;
  logic [15:0] ctl_rdata;
  logic        ctl_udqm;
  logic        ctl_ldqm;
  logic        ctl_init_done;
  logic        tmo_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_dat = 16'h0000;

  typedef struct {
    logic        we;
    logic [1:0]  sel;
    logic [20:0] adr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          lat;
    logic        ctl;
    logic        udqm;
    logic        ldqm;
  } vec_t;

  vec_t vecs[6];
  vec_t v;

  sdram_wb_responder dut (
    .clk_p(clk_p), .sdram_reset(sdram_reset), .sdram_stb(sdram_stb), .sdram_we(sdram_we),
    .sdram_sel(sdram_sel), .sdram_adr(sdram_adr), .sdram_out(sdram_out), .sdram_dat(sdram_dat),
    .sdram_ack(sdram_ack), .sdram_ready(sdram_ready), .ctl_wr_req(ctl_wr_req),
    .ctl_rd_req(ctl_rd_req), .ctl_wr_ack(ctl_wr_ack), .ctl_rd_ack(ctl_rd_ack),
    .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata), .ctl_rdata(ctl_rdata), .ctl_udqm(ctl_udqm),
    .ctl_ldqm(ctl_ldqm), .ctl_init_done(ctl_init_done), .tmo_err(tmo_err)
  );

  always #5 clk_p = ~clk_p;

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One kernel transaction; the bench plays the controller with a fixed ack latency
  task automatic run_txn(input vec_t t);
    sdram_we  = t.we;
    sdram_sel = t.sel;
    sdram_adr = t.adr;
    sdram_out = t.wdata;
    sdram_stb = 1'b1;
    tick();
    chk("udqm", ctl_udqm, t.udqm);
    chk("ldqm", ctl_ldqm, t.ldqm);
    chk("ack_early", sdram_ack, 0);
    if (t.ctl) begin
      chk("req_rise", t.we ? ctl_wr_req : ctl_rd_req, 1);
      chk("other_req", t.we ? ctl_rd_req : ctl_wr_req, 0);
      chk("ctl_addr", ctl_addr, {1'b0, t.adr});
      if (t.we) chk("ctl_wdata", ctl_wdata, t.wdata);
      for (int i = 1; i < t.lat; i++) begin
        tick();
        chk("req_hold", ctl_wr_req | ctl_rd_req, 1);
        chk("ack_wait", sdram_ack, 0);
      end
      ctl_rdata = t.rdata;
      if (t.we) ctl_wr_ack = 1'b1; else ctl_rd_ack = 1'b1;
      tick();
      ctl_wr_ack = 1'b0;
      ctl_rd_ack = 1'b0;
      chk("req_fall", ctl_wr_req | ctl_rd_req, 0);
      chk("ack_rise", sdram_ack, 1);
    end else begin
      chk("no_req0", ctl_wr_req | ctl_rd_req, 0);
      tick();
      chk("no_req1", ctl_wr_req | ctl_rd_req, 0);
      chk("ack_rise_local", sdram_ack, 1);
    end
    if (!t.we) exp_dat = t.rdata;
    chk("dat", sdram_dat, exp_dat);
    tick();
    chk("ack_hold", sdram_ack, 1);
    sdram_stb = 1'b0;
    tick();
    chk("ack_fall", sdram_ack, 0);
    chk("dat_stable", sdram_dat, exp_dat);
  endtask

  initial begin
    int n;
    vecs[0] = '{we:1'b1, sel:2'b11, adr:21'h01234, wdata:16'h5A5A, rdata:16'h0000, lat:3, ctl:1'b1, udqm:1'b0, ldqm:1'b0};
    vecs[1] = '{we:1'b0, sel:2'b11, adr:21'h01234, wdata:16'h0000, rdata:16'hBEEF, lat:6, ctl:1'b1, udqm:1'b0, ldqm:1'b0};
    vecs[2] = '{we:1'b1, sel:2'b10, adr:21'h00010, wdata:16'h1234, rdata:16'h0000, lat:1, ctl:1'b1, udqm:1'b0, ldqm:1'b1};
    vecs[3] = '{we:1'b1, sel:2'b01, adr:21'h00020, wdata:16'hA1B2, rdata:16'h0000, lat:2, ctl:1'b1, udqm:1'b1, ldqm:1'b0};
    vecs[4] = '{we:1'b1, sel:2'b00, adr:21'h00030, wdata:16'hFFFF, rdata:16'h0000, lat:1, ctl:1'b0, udqm:1'b1, ldqm:1'b1};
    vecs[5] = '{we:1'b0, sel:2'b00, adr:21'h1FFFFF, wdata:16'h0000, rdata:16'h0001, lat:1, ctl:1'b1, udqm:1'b0, ldqm:1'b0};

    sdram_reset = 1'b1; sdram_stb = 1'b0; sdram_we = 1'b0; sdram_sel = 2'b00;
    sdram_adr = '0; sdram_out = '0; ctl_wr_ack = 1'b0; ctl_rd_ack = 1'b0;
    ctl_rdata = '0; ctl_init_done = 1'b0;
    repeat (3) tick();
    chk("rst_ack", sdram_ack, 0);
    chk("rst_req", {ctl_wr_req, ctl_rd_req}, 0);
    chk("rst_masks", {ctl_udqm, ctl_ldqm}, 0);
    chk("rst_dat", sdram_dat, 0);
    chk("rst_tmo", tmo_err, 0);
    chk("rst_ready", sdram_ready, 0);

    // Kernel strobes before the controller is initialised: nothing happens
    sdram_reset = 1'b0;
    sdram_stb = 1'b1; sdram_we = 1'b1; sdram_sel = 2'b11;
    repeat (3) tick();
    chk("notready_req", ctl_wr_req, 0);
    chk("notready_ack", sdram_ack, 0);
    sdram_stb = 1'b0;
    ctl_init_done = 1'b1;
    repeat (2) tick();
    chk("ready", sdram_ready, 1);

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Wrong-type ack during a read is ignored
    sdram_we = 1'b0; sdram_sel = 2'b11; sdram_adr = 21'h00400; sdram_stb = 1'b1;
    tick();
    ctl_wr_ack = 1'b1;
    tick();
    ctl_wr_ack = 1'b0;
    chk("wrongack_req", ctl_rd_req, 1);
    chk("wrongack_ack", sdram_ack, 0);
    ctl_rdata = 16'h7E57; ctl_rd_ack = 1'b1;
    tick();
    ctl_rd_ack = 1'b0;
    exp_dat = 16'h7E57;
    chk("rightack_ack", sdram_ack, 1);
    chk("rightack_dat", sdram_dat, exp_dat);
    sdram_stb = 1'b0;
    tick();
    chk("rightack_fall", sdram_ack, 0);

    // Kernel aborts a read two cycles in: drain silently
    sdram_we = 1'b0; sdram_adr = 21'h00200; sdram_stb = 1'b1;
    tick();
    tick();
    sdram_stb = 1'b0;
    tick();
    chk("drain_req", ctl_rd_req, 1);
    chk("drain_ack", sdram_ack, 0);
    repeat (2) tick();
    chk("drain_req_hold", ctl_rd_req, 1);
    ctl_rdata = 16'hDEAD; ctl_rd_ack = 1'b1;
    tick();
    ctl_rd_ack = 1'b0;
    chk("drain_req_fall", ctl_rd_req, 0);
    chk("drain_noack", sdram_ack, 0);
    chk("drain_dat", sdram_dat, exp_dat);
    tick();
    chk("drain_noack2", sdram_ack, 0);
    run_txn(vecs[2]);

`ifdef SDRAM_RDCACHE_EN
    v = '{we:1'b0, sel:2'b11, adr:21'h00100, wdata:16'h0000, rdata:16'hA5C3, lat:2, ctl:1'b1, udqm:1'b0, ldqm:1'b0};
    run_txn(v);
    v.ctl = 1'b0;
    run_txn(v);
    v = '{we:1'b1, sel:2'b10, adr:21'h00100, wdata:16'h12FF, rdata:16'h0000, lat:2, ctl:1'b1, udqm:1'b0, ldqm:1'b1};
    run_txn(v);
    v = '{we:1'b0, sel:2'b11, adr:21'h00100, wdata:16'h0000, rdata:16'h12C3, lat:1, ctl:1'b0, udqm:1'b0, ldqm:1'b0};
    run_txn(v);
`else
    v = '{we:1'b0, sel:2'b11, adr:21'h00100, wdata:16'h0000, rdata:16'hA5C3, lat:2, ctl:1'b1, udqm:1'b0, ldqm:1'b0};
    run_txn(v);
    v.rdata = 16'h5555;
    run_txn(v);
`endif

    // Controller never answers: forced completion after the timeout
    sdram_we = 1'b0; sdram_sel = 2'b11; sdram_adr = 21'h00300; sdram_stb = 1'b1;
    tick();
    chk("tmo_req", ctl_rd_req, 1);
    chk("tmo_err_before", tmo_err, 0);
    n = 0;
    while (!sdram_ack && n < 2000) begin
      tick();
      n++;
    end
    chk("tmo_cycles", n, TMO + 1);
    chk("tmo_req_fall", ctl_rd_req, 0);
    chk("tmo_dat", sdram_dat, 0);
    chk("tmo_err", tmo_err, 1);
    exp_dat = 16'h0000;
    sdram_stb = 1'b0;
    tick();
    chk("tmo_ack_fall", sdram_ack, 0);
    chk("tmo_sticky", tmo_err, 1);

    // Reset while a write request is outstanding
    sdram_we = 1'b1; sdram_sel = 2'b11; sdram_adr = 21'h00500; sdram_out = 16'hC0DE; sdram_stb = 1'b1;
    tick();
    chk("rstmid_req", ctl_wr_req, 1);
    sdram_reset = 1'b1;
    tick();
    chk("rstmid_req_fall", ctl_wr_req, 0);
    chk("rstmid_ack", sdram_ack, 0);
    chk("rstmid_tmo_clr", tmo_err, 0);
    sdram_reset = 1'b0;
    sdram_stb = 1'b0;
    repeat (2) tick();
    exp_dat = 16'h0000;
    run_txn(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
